// File: rtl/bcd_game_timer_pkg.sv
// Shared constants and single-digit BCD helpers for the game timer.
package bcd_game_timer_pkg;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Returns {carry, digit}.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 5'b1_0000 : {1'b0, d + 4'd1};
  endfunction

  // Returns {borrow, digit}.
  function automatic logic [4:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? {1'b1, BCD_MAX} : {1'b0, d - 4'd1};
  endfunction

endpackage

// File: rtl/bcd_game_timer_sseg_decoder.sv
// One BCD digit to active-low seven-segment pattern; non-BCD codes blank.
module bcd_game_timer_sseg_decoder
  import bcd_game_timer_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= BCD_MAX) seg_o = SEG_DIGIT[bcd_i];
  end

endmodule

// File: rtl/bcd_game_timer.sv
// Prescaled up/down BCD game timer with sticky terminal flag and a
// time-multiplexed active-low seven-segment display driver.
module bcd_game_timer
  import bcd_game_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_BITS  = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cw,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_bcd,
  input  logic [4*NUM_DIGITS-1:0]   limit_bcd,
  output logic [4*NUM_DIGITS-1:0]   value_bcd,
  output logic                      done,
  output logic                      done_pulse,
  output logic [6:0]                sseg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [7*NUM_DIGITS-1:0]   time_sseg
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int PW    = $clog2(TICK_DIV);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int LO_W  = SCAN_BITS - SEL_W;

  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SEL_W:0] NUM_DIG_W  = (SEL_W + 1)'(NUM_DIGITS);

  logic [W-1:0]     value_q, value_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             pulse_q, pulse_d;
  logic [LO_W-1:0]  scan_lo_q;
  logic [SEL_W-1:0] sel_q;

  logic [W-1:0]     stepped;
  logic [W-1:0]     load_clamped;
  logic [4:0]       step_r;
  logic             cin;
  logic             run;
  logic             tick;
  logic             terminal;

  // Ripple the +1/-1 through the digits; a digit moves only when all lower digits wrapped.
  always_comb begin
    stepped = value_q;
    step_r  = 5'd0;
    cin     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step_r = cw ? bcd_inc(value_q[4*i +: 4]) : bcd_dec(value_q[4*i +: 4]);
      if (cin) stepped[4*i +: 4] = step_r[3:0];
      cin = cin & step_r[4];
    end
  end

  always_comb begin
    load_clamped = load_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_bcd[4*i +: 4] > BCD_MAX) load_clamped[4*i +: 4] = BCD_MAX;
    end
  end

  assign run      = en && !done_q;
  assign tick     = run && (presc_q == PRESC_LAST);
  assign terminal = cw ? (stepped == limit_bcd) : (stepped == '0);

  always_comb begin
    value_d = value_q;
    presc_d = presc_q;
    done_d  = done_q;
    pulse_d = 1'b0;
    if (load) begin
      value_d = load_clamped;
      presc_d = '0;
      done_d  = 1'b0;
    end else if (tick) begin
      presc_d = '0;
      value_d = stepped;
      if (terminal) begin
        done_d  = 1'b1;
        pulse_d = 1'b1;
      end
    end else if (run) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      value_q <= value_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
    end
  end

  // Scan counter split into a low part and the digit select that forms its top bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_lo_q <= '0;
      sel_q     <= '0;
    end else begin
      scan_lo_q <= scan_lo_q + 1'b1;
      if (&scan_lo_q) sel_q <= sel_q + 1'b1;
    end
  end

  logic [SEL_W-1:0] sel;
  logic             sel_ok;
  logic [3:0]       mux_digit;

  assign sel    = (NUM_DIGITS == 1) ? '0 : sel_q;
  assign sel_ok = ({1'b0, sel} < NUM_DIG_W);

  always_comb begin
    an        = '1;
    mux_digit = 4'd0;
    if (sel_ok) begin
      an[sel]   = 1'b0;
      mux_digit = value_q[{sel, 2'b00} +: 4];
    end
  end

  bcd_game_timer_sseg_decoder u_mux_dec (
    .bcd_i (mux_digit),
    .seg_o (sseg)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    bcd_game_timer_sseg_decoder u_dec (
      .bcd_i (value_q[4*gi +: 4]),
      .seg_o (time_sseg[7*gi +: 7])
    );
  end

  assign value_bcd  = value_q;
  assign done       = done_q;
  assign done_pulse = pulse_q;

endmodule

// File: tb/tb_bcd_game_timer.sv
// Bench for bcd_game_timer: integer-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bcd_game_timer;

  localparam int ND = 4;
  localparam int TD = 4;
  localparam int SB = 4;

  logic        clk = 1'b0;
  logic        rst, en, cw, load;
  logic [15:0] load_bcd, limit_bcd;
  logic [15:0] value_bcd;
  logic        done, done_pulse;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic [27:0] time_sseg;

  bcd_game_timer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_BITS(SB)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cw         (cw),
    .load       (load),
    .load_bcd   (load_bcd),
    .limit_bcd  (limit_bcd),
    .value_bcd  (value_bcd),
    .done       (done),
    .done_pulse (done_pulse),
    .sseg       (sseg),
    .an         (an),
    .time_sseg  (time_sseg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] an_tab  [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] s1234_tab [0:3] = '{7'h19, 7'h30, 7'h24, 7'h79};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    int r = 0;
    for (int i = 0; i < ND; i++) r = r + int'(b[4*i +: 4]) * pow10(i);
    return r;
  endfunction

  function automatic int clamp_int(input logic [15:0] b);
    int r = 0;
    for (int i = 0; i < ND; i++) r = r + ((b[4*i +: 4] > 4'd9) ? 9 : int'(b[4*i +: 4])) * pow10(i);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  typedef struct packed {
    int val;
    int presc;
    bit done;
    bit pulse;
  } mst_t;

  mst_t m;
  int   m_scan;

  // Timer behaviour expressed as decimal arithmetic on the displayed number.
  function automatic mst_t mnext(input mst_t s, input logic ld, input logic [15:0] lb,
                                 input logic e, input logic c, input logic [15:0] lim);
    mst_t n = s;
    n.pulse = 1'b0;
    if (ld) begin
      n.val   = clamp_int(lb);
      n.presc = 0;
      n.done  = 1'b0;
    end else if (e && !s.done) begin
      if (s.presc == TD - 1) begin
        n.presc = 0;
        n.val   = c ? (s.val + 1) % 10000 : (s.val + 9999) % 10000;
        if (c ? (n.val == bcd2int(lim)) : (n.val == 0)) begin
          n.done  = 1'b1;
          n.pulse = 1'b1;
        end
      end else begin
        n.presc = s.presc + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m      <= '0;
      m_scan <= 0;
    end else begin
      m      <= mnext(m, load, load_bcd, en, cw, limit_bcd);
      m_scan <= (m_scan + 1) % (1 << SB);
    end
  end

  function automatic logic [27:0] exp_time_sseg(input int v);
    logic [27:0] r = '0;
    for (int i = 0; i < ND; i++) r[7*i +: 7] = seg_tab[(v / pow10(i)) % 10];
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int sel;
      sel = (m_scan >> (SB - 2)) % ND;
      chk("value",      value_bcd,  int2bcd(m.val));
      chk("done",       done,       m.done);
      chk("done_pulse", done_pulse, m.pulse);
      chk("an",         an,         4'b1111 & ~(4'b0001 << sel));
      chk("sseg",       sseg,       seg_tab[(m.val / pow10(sel)) % 10]);
      chk("time_sseg",  time_sseg,  exp_time_sseg(m.val));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_bcd = v;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
  endtask

  initial begin
    int cnt;
    en = 1'b0; cw = 1'b1; load = 1'b0; load_bcd = '0; limit_bcd = 16'h0010;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("rst_value", value_bcd, 16'h0000);
    chk("rst_done",  done,       1'b0);
    chk("rst_pulse", done_pulse, 1'b0);
    chk("rst_an",    an,         4'b1110);
    chk("rst_sseg",  sseg,       7'b1000000);
    chk("rst_time",  time_sseg,  {4{7'h40}});

    // 1: count up to limit 0010
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b1; chk_en = 1'b1;
    cnt = 0;
    while (value_bcd !== 16'h0010 && cnt < 100) begin
      step(1);
      cnt++;
    end
    chk("t1_cycles", cnt, 40);
    chk("t1_pulse",  done_pulse, 1'b1);
    chk("t1_done",   done, 1'b1);
    step(1);
    chk("t1_pulse_gone", done_pulse, 1'b0);
    step(20);
    chk("t1_frozen", value_bcd, 16'h0010);

    // 2: down-count borrow chain, reach 0
    cw = 1'b0;
    do_load(16'h0100);
    chk("t2_load",  value_bcd, 16'h0100);
    chk("t2_clear", done, 1'b0);
    step(4);
    chk("t2_borrow", value_bcd, 16'h0099);
    do_load(16'h0001);
    step(4);
    chk("t2_zero",  value_bcd, 16'h0000);
    chk("t2_done",  done, 1'b1);

    // 3: pause keeps partial period
    cw = 1'b1; limit_bcd = 16'h9999;
    do_load(16'h0003);
    step(2);
    en = 1'b0;
    step(10);
    chk("t3_paused", value_bcd, 16'h0003);
    en = 1'b1;
    step(1);
    chk("t3_resume1", value_bcd, 16'h0003);
    step(1);
    chk("t3_resume2", value_bcd, 16'h0004);

    // 4: load beats tick; nibble clamp
    do_load(16'h0000);
    step(3);
    do_load(16'h0500);
    chk("t4_load_wins", value_bcd, 16'h0500);
    step(3);
    chk("t4_no_step", value_bcd, 16'h0500);
    do_load(16'h00F3);
    chk("t4_clamp", value_bcd, 16'h0093);

    // 5: wrap from 9999, async reset mid-period
    limit_bcd = 16'h0002;
    do_load(16'h9999);
    step(4);
    chk("t5_wrap", value_bcd, 16'h0000);
    chk("t5_wrap_done", done, 1'b0);
    step(4);
    chk("t5_one", value_bcd, 16'h0001);
    step(4);
    chk("t5_two", value_bcd, 16'h0002);
    chk("t5_done", done, 1'b1);
    chk("t5_pulse", done_pulse, 1'b1);
    do_load(16'h0000);
    step(2);
    rst = 1'b0;
    #1;
    chk("t5_rst_value", value_bcd, 16'h0000);
    chk("t5_rst_done",  done, 1'b0);
    chk("t5_rst_pulse", done_pulse, 1'b0);
    chk("t5_rst_an",    an, 4'b1110);
    chk("t5_rst_sseg",  sseg, 7'b1000000);

    // 6: display scan of 1234
    en = 1'b0; load_bcd = 16'h1234; load = 1'b1;
    step(1);
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      load = 1'b0;
      chk("t6_an",   an,   an_tab[(k / 4) % 4]);
      chk("t6_sseg", sseg, s1234_tab[(k / 4) % 4]);
      chk("t6_time", time_sseg, {7'h79, 7'h24, 7'h30, 7'h19});
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      en = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 9) == 0) cw = ~cw;
      if ($urandom_range(0, 19) == 0) limit_bcd = int2bcd($urandom_range(0, 40));
      load = ($urandom_range(0, 49) == 0);
      if (load) load_bcd = ($urandom_range(0, 1) == 1) ? int2bcd($urandom_range(0, 60))
                                                      : 16'($urandom);
      step(1);
    end
    load = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
